// File: rtl/dma_h2c_arb_pkg.sv
// Shared types and default widths for the H2C AXI-Stream round-robin arbiter.
package dma_h2c_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_e;

  localparam int H2C_DATA_W = 512;
  localparam int H2C_USER_W = 64;

endpackage

// File: rtl/dma_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i+1
// (mod NUM_CH), returned one-hot; all zero when nothing requests.
module dma_rr_pick #(
  parameter  int NUM_CH = 4,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [CH_W-1:0]   ptr_i,
  output logic [NUM_CH-1:0] gnt_o
);

  // One spare bit so ptr + offset never wraps before the modulo.
  localparam int SUM_W = CH_W + 1;

  logic [SUM_W-1:0] sum;
  logic [CH_W-1:0]  idx;

  // Walk the search order backwards so the earliest hit is written last.
  always_comb begin
    gnt_o = '0;
    sum   = '0;
    idx   = '0;
    for (int i = NUM_CH; i >= 1; i--) begin
      sum = {1'b0, ptr_i} + SUM_W'(i);
      idx = CH_W'(sum % SUM_W'(NUM_CH));
      if (req_i[idx]) begin
        gnt_o      = '0;
        gnt_o[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dma_h2c_axis_rr_arb.sv
// Packet-granular round-robin merge of NUM_CH H2C AXI-Stream channels onto one
// registered output stream; a grant is held from the first beat to tlast.
module dma_h2c_axis_rr_arb
  import dma_h2c_arb_pkg::*;
#(
  parameter  int NUM_CH = 4,
  parameter  int DATA_W = H2C_DATA_W,
  parameter  int USER_W = DATA_W / 8,
  localparam int CH_W   = $clog2(NUM_CH),
  localparam int KEEP_W = DATA_W / 8
) (
  input  logic                     axi_aclk,
  input  logic                     axi_aresetn,
  input  logic [NUM_CH*DATA_W-1:0] s_tdata,
  input  logic [NUM_CH*KEEP_W-1:0] s_tparity,
  input  logic [NUM_CH*KEEP_W-1:0] s_tkeep,
  input  logic [NUM_CH*USER_W-1:0] s_tusr,
  input  logic [NUM_CH-1:0]        s_tlast,
  input  logic [NUM_CH-1:0]        s_tvalid,
  output logic [NUM_CH-1:0]        s_tready,
  output logic [DATA_W-1:0]        m_tdata,
  output logic [KEEP_W-1:0]        m_tparity,
  output logic [KEEP_W-1:0]        m_tkeep,
  output logic [USER_W-1:0]        m_tusr,
  output logic                     m_tlast,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  input  logic [NUM_CH-1:0]        ch_en,
  output logic [NUM_CH-1:0]        cur_grant,
  output logic                     pkt_done,
  output logic [CH_W-1:0]          pkt_ch,
  output arb_state_e               dbg_state_o
);

  function automatic logic [CH_W-1:0] oh2idx(input logic [NUM_CH-1:0] oh);
    oh2idx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (oh[i]) oh2idx = CH_W'(i);
    end
  endfunction

  arb_state_e          state_q;
  logic [NUM_CH-1:0]   grant_q;
  logic [CH_W-1:0]     gidx_q;
  logic [CH_W-1:0]     last_ptr_q;

  logic [DATA_W-1:0]   m_tdata_q;
  logic [KEEP_W-1:0]   m_tparity_q;
  logic [KEEP_W-1:0]   m_tkeep_q;
  logic [USER_W-1:0]   m_tusr_q;
  logic                m_tlast_q;
  logic                m_tvalid_q;
  logic [CH_W-1:0]     tag_q;
  logic                pkt_done_q;
  logic [CH_W-1:0]     pkt_ch_q;

  logic [NUM_CH-1:0]   cand;
  logic [NUM_CH-1:0]   pick;
  logic                out_free;
  logic                accept;
  logic                m_fire;
  logic [DATA_W-1:0]   sel_data;
  logic [KEEP_W-1:0]   sel_parity;
  logic [KEEP_W-1:0]   sel_keep;
  logic [USER_W-1:0]   sel_usr;
  logic                sel_last;

  assign cand = s_tvalid & ch_en;

  dma_rr_pick #(.NUM_CH(NUM_CH)) u_pick (
    .req_i (cand),
    .ptr_i (last_ptr_q),
    .gnt_o (pick)
  );

  // A beat moves on either side only when valid and ready are both high at the
  // clock edge; valid never waits on ready, and s_tready is a function of
  // registered state and m_tready only (never of s_tvalid).
  assign out_free = !m_tvalid_q || m_tready;
  assign s_tready = (state_q == XFER && out_free) ? grant_q : '0;
  assign accept   = |(s_tready & s_tvalid);
  assign m_fire   = m_tvalid_q && m_tready;

  assign sel_data   = s_tdata  [int'(gidx_q)*DATA_W +: DATA_W];
  assign sel_parity = s_tparity[int'(gidx_q)*KEEP_W +: KEEP_W];
  assign sel_keep   = s_tkeep  [int'(gidx_q)*KEEP_W +: KEEP_W];
  assign sel_usr    = s_tusr   [int'(gidx_q)*USER_W +: USER_W];
  assign sel_last   = s_tlast[gidx_q];

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      gidx_q     <= '0;
      last_ptr_q <= CH_W'(NUM_CH - 1);
    end else begin
      case (state_q)
        IDLE: begin
          if (|cand) begin
            grant_q <= pick;
            gidx_q  <= oh2idx(pick);
            state_q <= XFER;
          end
        end
        XFER: begin
          if (accept && sel_last) begin
            grant_q    <= '0;
            last_ptr_q <= gidx_q;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Output stage loads only when empty or draining, so a stalled beat never changes.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      m_tdata_q   <= '0;
      m_tparity_q <= '0;
      m_tkeep_q   <= '0;
      m_tusr_q    <= '0;
      m_tlast_q   <= 1'b0;
      m_tvalid_q  <= 1'b0;
      tag_q       <= '0;
    end else if (accept) begin
      m_tdata_q   <= sel_data;
      m_tparity_q <= sel_parity;
      m_tkeep_q   <= sel_keep;
      m_tusr_q    <= sel_usr;
      m_tlast_q   <= sel_last;
      m_tvalid_q  <= 1'b1;
      tag_q       <= gidx_q;
    end else if (m_tready) begin
      m_tvalid_q  <= 1'b0;
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      pkt_done_q <= 1'b0;
      pkt_ch_q   <= '0;
    end else begin
      pkt_done_q <= m_fire && m_tlast_q;
      if (m_fire && m_tlast_q) pkt_ch_q <= tag_q;
    end
  end

  assign m_tdata     = m_tdata_q;
  assign m_tparity   = m_tparity_q;
  assign m_tkeep     = m_tkeep_q;
  assign m_tusr      = m_tusr_q;
  assign m_tlast     = m_tlast_q;
  assign m_tvalid    = m_tvalid_q;
  assign cur_grant   = grant_q;
  assign pkt_done    = pkt_done_q;
  assign pkt_ch      = pkt_ch_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dma_h2c_axis_rr_arb.sv
// Directed bench for dma_h2c_axis_rr_arb: per-channel packet sources, an
// in-order beat scoreboard on the merged stream and grant-order checks.
`timescale 1ns/1ps
module tb_dma_h2c_axis_rr_arb;
  import dma_h2c_arb_pkg::*;

  localparam int NC = 4;
  localparam int DW = 512;
  localparam int KW = DW / 8;
  localparam int UW = DW / 8;
  localparam int CW = 2;

  logic              axi_aclk;
  logic              axi_aresetn;
  logic [NC*DW-1:0]  s_tdata;
  logic [NC*KW-1:0]  s_tparity;
  logic [NC*KW-1:0]  s_tkeep;
  logic [NC*UW-1:0]  s_tusr;
  logic [NC-1:0]     s_tlast;
  logic [NC-1:0]     s_tvalid;
  logic [NC-1:0]     s_tready;
  logic [DW-1:0]     m_tdata;
  logic [KW-1:0]     m_tparity;
  logic [KW-1:0]     m_tkeep;
  logic [UW-1:0]     m_tusr;
  logic              m_tlast;
  logic              m_tvalid;
  logic              m_tready;
  logic [NC-1:0]     ch_en;
  logic [NC-1:0]     cur_grant;
  logic              pkt_done;
  logic [CW-1:0]     pkt_ch;
  arb_state_e        dbg_state;

  dma_h2c_axis_rr_arb #(.NUM_CH(NC), .DATA_W(DW), .USER_W(UW)) dut (
    .axi_aclk    (axi_aclk),
    .axi_aresetn (axi_aresetn),
    .s_tdata     (s_tdata),
    .s_tparity   (s_tparity),
    .s_tkeep     (s_tkeep),
    .s_tusr      (s_tusr),
    .s_tlast     (s_tlast),
    .s_tvalid    (s_tvalid),
    .s_tready    (s_tready),
    .m_tdata     (m_tdata),
    .m_tparity   (m_tparity),
    .m_tkeep     (m_tkeep),
    .m_tusr      (m_tusr),
    .m_tlast     (m_tlast),
    .m_tvalid    (m_tvalid),
    .m_tready    (m_tready),
    .ch_en       (ch_en),
    .cur_grant   (cur_grant),
    .pkt_done    (pkt_done),
    .pkt_ch      (pkt_ch),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial axi_aclk = 1'b0;
  always #5 axi_aclk = ~axi_aclk;

  initial begin
    #1000000;
    $display("FAIL watchdog: sim time %0t reached, expected finish earlier", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- payload patterns ----------------
  function automatic logic [DW-1:0] mk_data(input int ch, input int seq);
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = {8'(8'hA0 + ch), 8'(seq), 8'(i), 8'h5C};
    return d;
  endfunction

  function automatic logic [KW-1:0] mk_par(input int ch, input int seq);
    return 64'h0123_4567_89AB_CDEF ^ {8{8'(ch * 16 + seq)}};
  endfunction

  function automatic logic [KW-1:0] mk_keep(input int ch, input int seq);
    return ~(64'(seq & 255) << (8 * ch));
  endfunction

  function automatic logic [UW-1:0] mk_usr(input int ch, input int seq);
    return 64'hFEED_0000_0000_0000 | 64'((ch << 16) | seq);
  endfunction

  // ---------------- sources (driver) ----------------
  int src_npkt [NC];
  int src_len  [NC];
  int src_beat [NC];
  int src_seq  [NC];
  int src_stall_at   [NC];
  int src_stall_left [NC];
  logic rand_ready;

  task automatic set_src(input int c, input int npkt, input int len);
    src_npkt[c] = npkt;
    src_len[c]  = len;
    src_beat[c] = 0;
    src_stall_left[c] = 0;
  endtask

  task automatic drive_srcs();
    for (int c = 0; c < NC; c++) begin
      logic v;
      v = (src_npkt[c] > 0) && !(src_stall_left[c] > 0 && src_seq[c] == src_stall_at[c]);
      s_tvalid[c] = v;
      s_tlast[c]  = (src_beat[c] == src_len[c] - 1);
      s_tdata  [c*DW +: DW] = mk_data(c, src_seq[c] & 12'hFFF);
      s_tparity[c*KW +: KW] = mk_par (c, src_seq[c] & 12'hFFF);
      s_tkeep  [c*KW +: KW] = mk_keep(c, src_seq[c] & 12'hFFF);
      s_tusr   [c*UW +: UW] = mk_usr (c, src_seq[c] & 12'hFFF);
    end
  endtask

  initial begin
    forever begin
      @(posedge axi_aclk);
      #1;
      m_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      drive_srcs();
    end
  end

  // ---------------- scoreboard / monitor ----------------
  logic [15:0] exp_q[$];          // {last, ch[2:0], seq[11:0]}
  int          grant_log[$];
  int          cyc = 0;
  int          first_hs = -1;
  int          last_hs  = -1;
  int          m_beats  = 0;
  int          done_cnt = 0;
  logic        exp_done = 1'b0;
  logic [CW-1:0] exp_done_ch = '0;
  logic [NC-1:0] prev_grant = '0;
  logic        hold_pend = 1'b0;
  logic [DW-1:0] hold_data;
  logic [UW-1:0] hold_usr;
  logic        hold_last;

  initial begin
    logic [15:0] e;
    forever begin
      @(negedge axi_aclk);
      cyc++;
      if (!axi_aresetn) begin
        exp_done   = 1'b0;
        hold_pend  = 1'b0;
        prev_grant = '0;
      end else begin
        check("grant_onehot", 1'($onehot0(cur_grant)), 1'b1);
        if (cur_grant != '0 && prev_grant == '0) begin
          for (int c = 0; c < NC; c++) if (cur_grant[c]) grant_log.push_back(c);
        end
        prev_grant = cur_grant;

        check("pkt_done", pkt_done, exp_done);
        if (exp_done) begin
          check("pkt_ch", pkt_ch, exp_done_ch);
          done_cnt++;
        end
        exp_done = 1'b0;

        if (hold_pend) begin
          check("hold_valid", m_tvalid, 1'b1);
          check("hold_data", m_tdata, hold_data);
          check("hold_usr", m_tusr, hold_usr);
          check("hold_last", m_tlast, hold_last);
        end
        hold_pend = m_tvalid && !m_tready;
        hold_data = m_tdata;
        hold_usr  = m_tusr;
        hold_last = m_tlast;

        if (m_tvalid && m_tready) begin
          if (exp_q.size() == 0) begin
            check("spurious_beat", m_tvalid, 1'b0);
          end else begin
            e = exp_q.pop_front();
            check("m_tdata",   m_tdata,   mk_data(int'(e[14:12]), int'(e[11:0])));
            check("m_tparity", m_tparity, mk_par (int'(e[14:12]), int'(e[11:0])));
            check("m_tkeep",   m_tkeep,   mk_keep(int'(e[14:12]), int'(e[11:0])));
            check("m_tusr",    m_tusr,    mk_usr (int'(e[14:12]), int'(e[11:0])));
            check("m_tlast",   m_tlast,   e[15]);
            exp_done_ch = CW'(e[14:12]);
          end
          exp_done = m_tlast;
          m_beats++;
        end

        for (int c = 0; c < NC; c++) begin
          if (s_tvalid[c] && s_tready[c]) begin
            exp_q.push_back({(src_beat[c] == src_len[c] - 1) ? 1'b1 : 1'b0, 3'(c), 12'(src_seq[c])});
            if (first_hs < 0) first_hs = cyc;
            last_hs = cyc;
            src_seq[c]++;
            src_beat[c]++;
            if (src_beat[c] == src_len[c]) begin
              src_beat[c] = 0;
              src_npkt[c]--;
            end
          end
        end
        for (int c = 0; c < NC; c++) begin
          if (src_npkt[c] > 0 && src_stall_left[c] > 0 && src_seq[c] == src_stall_at[c])
            src_stall_left[c]--;
        end
      end
    end
  end

  task automatic wait_done(input string tag, input logic [NC-1:0] mask, input int budget);
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < budget && !ok; k++) begin
      @(negedge axi_aclk);
      #1;
      ok = (exp_q.size() == 0) && (dbg_state == IDLE) && !m_tvalid;
      for (int c = 0; c < NC; c++) if (mask[c] && src_npkt[c] != 0) ok = 1'b0;
    end
    check(tag, ok, 1'b1);
  endtask

  task automatic start_phase();
    @(posedge axi_aclk);
    #2;
    grant_log.delete();
    first_hs = -1;
    last_hs  = -1;
    m_beats  = 0;
    done_cnt = 0;
  endtask

  // ---------------- directed tests ----------------
  int exp_rr[8];
  int seq0;
  logic seen;

  initial begin
    exp_rr = '{3, 0, 1, 2, 3, 0, 1, 2};
    axi_aresetn = 1'b0;
    m_tready    = 1'b1;
    rand_ready  = 1'b0;
    ch_en       = '1;
    for (int c = 0; c < NC; c++) begin
      set_src(c, 0, 1);
      src_seq[c] = c * 100;
      src_stall_at[c] = -1;
    end
    drive_srcs();

    // Reset values while held in reset
    #12;
    check("rst_m_tvalid", m_tvalid, 1'b0);
    check("rst_m_tlast", m_tlast, 1'b0);
    check("rst_m_tdata", m_tdata, '0);
    check("rst_m_tparity", m_tparity, '0);
    check("rst_m_tkeep", m_tkeep, '0);
    check("rst_m_tusr", m_tusr, '0);
    check("rst_cur_grant", cur_grant, '0);
    check("rst_s_tready", s_tready, '0);
    check("rst_pkt_done", pkt_done, 1'b0);
    check("rst_pkt_ch", pkt_ch, '0);
    check("rst_state", dbg_state, IDLE);
    @(posedge axi_aclk);
    #2;
    axi_aresetn = 1'b1;

    // Single channel: ch2, 4 beats, latency and pkt_done
    start_phase();
    seq0 = src_seq[2];
    set_src(2, 1, 4);
    drive_srcs();
    @(negedge axi_aclk);
    check("lat0_grant", cur_grant, 4'b0000);
    check("lat0_m_tvalid", m_tvalid, 1'b0);
    @(negedge axi_aclk);
    check("lat1_grant", cur_grant, 4'b0100);
    check("lat1_s_tready", s_tready, 4'b0100);
    check("lat1_m_tvalid", m_tvalid, 1'b0);
    @(negedge axi_aclk);
    check("lat2_m_tvalid", m_tvalid, 1'b1);
    check("lat2_m_tdata", m_tdata, mk_data(2, seq0));
    wait_done("single_done", 4'b0100, 100);
    check("single_beats", m_beats, 4);
    check("single_s_span", last_hs - first_hs, 3);
    check("single_pkts", done_cnt, 1);
    check("single_nlog", grant_log.size(), 1);
    if (grant_log.size() > 0) check("single_grant", grant_log[0], 2);

    // Round robin: all channels, two 2-beat packets each, pointer starts after ch2
    start_phase();
    for (int c = 0; c < NC; c++) set_src(c, 2, 2);
    drive_srcs();
    wait_done("rr_done", 4'b1111, 200);
    check("rr_nlog", grant_log.size(), 8);
    for (int i = 0; i < 8; i++) if (i < grant_log.size()) check("rr_order", grant_log[i], exp_rr[i]);
    check("rr_s_span", last_hs - first_hs, 22);
    check("rr_beats", m_beats, 16);
    check("rr_pkts", done_cnt, 8);

    // Backpressure: 16-beat packet on ch1 with random m_tready
    start_phase();
    rand_ready = 1'b1;
    set_src(1, 1, 16);
    drive_srcs();
    wait_done("bp_done", 4'b0010, 400);
    rand_ready = 1'b0;
    check("bp_beats", m_beats, 16);
    check("bp_pkts", done_cnt, 1);
    check("bp_nlog", grant_log.size(), 1);
    if (grant_log.size() > 0) check("bp_grant", grant_log[0], 1);

    // Mask A: only ch1/ch3 enabled while all four request
    start_phase();
    ch_en = 4'b1010;
    set_src(0, 1, 1);
    set_src(1, 1, 2);
    set_src(2, 1, 1);
    set_src(3, 2, 2);
    drive_srcs();
    wait_done("maskA_done", 4'b1010, 200);
    check("maskA_nlog", grant_log.size(), 3);
    if (grant_log.size() > 2) begin
      check("maskA_g0", grant_log[0], 3);
      check("maskA_g1", grant_log[1], 1);
      check("maskA_g2", grant_log[2], 3);
    end

    // Mask B: disable ch1 mid-packet; packet completes, ch3 wins next
    start_phase();
    set_src(1, 2, 6);
    set_src(3, 1, 2);
    drive_srcs();
    seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge axi_aclk);
      #1;
      seen = (src_beat[1] >= 2);
    end
    check("maskB_midpkt", seen, 1'b1);
    ch_en = 4'b1000;
    wait_done("maskB_done", 4'b1000, 200);
    check("maskB_nlog", grant_log.size(), 2);
    if (grant_log.size() > 1) begin
      check("maskB_g0", grant_log[0], 1);
      check("maskB_g1", grant_log[1], 3);
    end
    check("maskB_beats", m_beats, 8);
    check("maskB_ch1_left", src_npkt[1], 1);
    for (int k = 0; k < 3; k++) begin
      @(negedge axi_aclk);
      check("maskB_idle", cur_grant, 4'b0000);
    end
    @(posedge axi_aclk);
    #2;
    for (int c = 0; c < NC; c++) set_src(c, 0, 1);
    ch_en = '1;
    drive_srcs();

    // Source stall: ch0 pauses 5 cycles mid-packet while ch1 waits
    start_phase();
    set_src(0, 1, 8);
    src_stall_at[0]   = src_seq[0] + 3;
    src_stall_left[0] = 5;
    set_src(1, 1, 2);
    drive_srcs();
    seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge axi_aclk);
      #1;
      seen = !s_tvalid[0] && src_beat[0] == 3;
    end
    check("stall_seen", seen, 1'b1);
    for (int k = 0; k < 5; k++) begin
      check("stall_grant", cur_grant, 4'b0001);
      check("stall_ch1_ready", s_tready[1], 1'b0);
      @(negedge axi_aclk);
      #1;
    end
    wait_done("stall_done", 4'b0011, 200);
    check("stall_nlog", grant_log.size(), 2);
    if (grant_log.size() > 1) begin
      check("stall_g0", grant_log[0], 0);
      check("stall_g1", grant_log[1], 1);
    end
    check("stall_beats", m_beats, 10);

    // Asynchronous reset mid-packet, then ch0 must be first after release
    start_phase();
    set_src(1, 1, 16);
    drive_srcs();
    for (int k = 0; k < 6; k++) @(negedge axi_aclk);
    #2;
    axi_aresetn = 1'b0;
    #1;
    check("arst_m_tvalid", m_tvalid, 1'b0);
    check("arst_m_tlast", m_tlast, 1'b0);
    check("arst_m_tdata", m_tdata, '0);
    check("arst_m_tusr", m_tusr, '0);
    check("arst_cur_grant", cur_grant, '0);
    check("arst_s_tready", s_tready, '0);
    check("arst_pkt_done", pkt_done, 1'b0);
    check("arst_pkt_ch", pkt_ch, '0);
    check("arst_state", dbg_state, IDLE);
    for (int c = 0; c < NC; c++) set_src(c, 0, 1);
    exp_q.delete();
    drive_srcs();
    @(posedge axi_aclk);
    @(posedge axi_aclk);
    #2;
    axi_aresetn = 1'b1;
    start_phase();
    set_src(0, 1, 1);
    set_src(2, 1, 1);
    drive_srcs();
    wait_done("post_rst_done", 4'b0101, 100);
    check("post_rst_nlog", grant_log.size(), 2);
    if (grant_log.size() > 1) begin
      check("post_rst_g0", grant_log[0], 0);
      check("post_rst_g1", grant_log[1], 2);
    end
    check("single_beat_span", last_hs - first_hs, 2);
    check("post_rst_pkts", done_cnt, 2);

    repeat (3) @(negedge axi_aclk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
